// File: rtl/hyperbus_delay_cfg.sv
// HyperBus delay-line configuration stage.
// Takes a tap request over valid/ready and clamps it to the implemented range.
// A changed value is applied only while the bus is idle, and the bus stays
// blocked for a settle window after the delay-line select changes.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | ready for a request; unchanged requests complete from here
// WAIT_IDLE  | request pending, bus blocked, waiting for bus_idle_i
// APPLY      | bus idle; delay_o takes the pending value on the next edge
// SETTLE     | delay line settling; counter runs down to 0, then done_o
module hyperbus_delay_cfg #(
    parameter int TAP_W         = 3,
    parameter int SETTLE_CYCLES = 4,
    parameter int RST_DELAY     = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] cfg_delay_i,
    input  logic        cfg_valid_i,
    output logic        cfg_ready_o,
    input  logic        bus_idle_i,
    output logic        block_o,
    output logic [31:0] delay_o,
    output logic        done_o,
    output logic        clamp_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_IDLE,
        ST_APPLY,
        ST_SETTLE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [TAP_W-1:0] pend_q;
    logic [TAP_W-1:0] delay_q;
    logic [TAP_W-1:0] req_val;
    logic             req_clamp;
    logic             clamp_flag_q;
    logic             accept;
    logic             same;
    logic [7:0]       cnt_q;
    logic             done_q;
    logic             clamp_out_q;

    // Any set bit above the implemented taps saturates the request to all-ones.
    assign req_clamp = |(cfg_delay_i >> TAP_W);
    assign req_val   = req_clamp ? '1 : cfg_delay_i[TAP_W-1:0];
    assign accept    = cfg_valid_i && (state_q == ST_IDLE);
    assign same      = (req_val == delay_q);

    assign cfg_ready_o = (state_q == ST_IDLE);
    assign block_o     = (state_q != ST_IDLE);
    assign delay_o     = 32'(delay_q);
    assign done_o      = done_q;
    assign clamp_o     = clamp_out_q;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (accept && !same) state_d = ST_WAIT_IDLE;
            ST_WAIT_IDLE: if (bus_idle_i) state_d = ST_APPLY;
            ST_APPLY:     state_d = ST_SETTLE;
            ST_SETTLE:    if (cnt_q == 8'd0) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pending request, delay select, settle counter and completion pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q       <= '0;
            clamp_flag_q <= 1'b0;
            delay_q      <= TAP_W'(RST_DELAY);
            cnt_q        <= 8'd0;
            done_q       <= 1'b0;
            clamp_out_q  <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            clamp_out_q <= 1'b0;
            if (accept) begin
                pend_q       <= req_val;
                clamp_flag_q <= req_clamp;
                if (same) begin
                    done_q      <= 1'b1;
                    clamp_out_q <= req_clamp;
                end
            end
            if (state_q == ST_APPLY) begin
                delay_q <= pend_q;
                cnt_q   <= 8'(SETTLE_CYCLES - 1);
            end else if (state_q == ST_SETTLE) begin
                if (cnt_q == 8'd0) begin
                    done_q      <= 1'b1;
                    clamp_out_q <= clamp_flag_q;
                end else begin
                    cnt_q <= cnt_q - 8'd1;
                end
            end
        end
    end

endmodule
